// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encoding and default 640x480@60 timing,
// common to the pattern generator and vga_controller.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_XOR   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Position-in / pixel-out bundle between the raster source and the pattern generator.
interface vga_pattern_gen_if
    import vga_pkg::*;
#(
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int COLOR_BITS = 3,
    parameter int FRAME_BITS = 8
);
    logic [XW-1:0]         i_x_pos;
    logic [YW-1:0]         i_y_pos;
    logic                  i_valid;
    mode_e                 i_mode;
    logic                  i_anim_en;
    logic [COLOR_BITS-1:0] o_r;
    logic [COLOR_BITS-1:0] o_g;
    logic [COLOR_BITS-1:0] o_b;
    logic                  o_valid;
    logic [FRAME_BITS-1:0] o_frame_cnt;

    modport master (
        output i_x_pos, i_y_pos, i_valid, i_mode, i_anim_en,
        input  o_r, o_g, o_b, o_valid, o_frame_cnt
    );

    modport slave (
        input  i_x_pos, i_y_pos, i_valid, i_mode, i_anim_en,
        output o_r, o_g, o_b, o_valid, o_frame_cnt
    );
endinterface

// File: rtl/vga_frame_tracker.sv
// Start-of-frame detection, frame-boundary latching of mode/animation and the
// animation frame counter.
module vga_frame_tracker
    import vga_pkg::*;
#(
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int FRAME_BITS = 8
) (
    input  logic                  i_Clk,
    input  logic                  rst,
    input  logic [XW-1:0]         x_pos,
    input  logic [YW-1:0]         y_pos,
    input  logic                  valid,
    input  mode_e                 req_mode,
    input  logic                  req_anim,
    output mode_e                 mode,
    output logic                  anim,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    logic                  at_origin;
    logic                  origin_q;
    logic                  sof;
    mode_e                 mode_q;
    logic                  anim_q;
    logic [FRAME_BITS-1:0] cnt_q;

    // Holding (0,0) for several cycles must still count as one frame start.
    assign at_origin = valid && (x_pos == '0) && (y_pos == '0);
    assign sof       = at_origin && !origin_q;

    // The sof pixel already sees the requested settings but the old count.
    assign mode      = sof ? req_mode : mode_q;
    assign anim      = sof ? req_anim : anim_q;
    assign frame_cnt = cnt_q;

    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst) begin
            origin_q <= 1'b0;
            mode_q   <= MODE_XOR;
            anim_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            origin_q <= at_origin;
            if (sof) begin
                mode_q <= req_mode;
                anim_q <= req_anim;
                if (req_anim)
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source (XOR, bars, checker, gradient) with
// optional per-frame animation; fixed 2-cycle latency from position to pixel.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int XW            = $clog2(H_ACTIVE),
    parameter int YW            = $clog2(V_ACTIVE),
    parameter int COLOR_BITS    = 3,
    parameter int FRAME_BITS    = 8,
    parameter int XOR_SHIFT     = 5,
    parameter int BAR_SHIFT     = 6,
    parameter int CHK_SHIFT     = 5,
    parameter int CHK_PHASE_BIT = 4
) (
    input  logic              i_Clk,
    input  logic              rst,
    vga_pattern_gen_if.slave  bus
);

    localparam int STAGES = 2;

    generate
        if (XOR_SHIFT + COLOR_BITS > XW) begin : g_bad_xor
            $error("XOR field exceeds x width");
        end
        if (BAR_SHIFT + 3 > XW) begin : g_bad_bar
            $error("bar index exceeds x width");
        end
        if (COLOR_BITS > YW || COLOR_BITS > XW || COLOR_BITS > FRAME_BITS) begin : g_bad_cb
            $error("COLOR_BITS too wide for position or frame counter");
        end
        if (CHK_SHIFT >= XW || CHK_SHIFT >= YW || CHK_PHASE_BIT >= FRAME_BITS) begin : g_bad_chk
            $error("checker bit selects out of range");
        end
    endgenerate

    typedef struct packed {
        mode_e                 mode;
        logic [COLOR_BITS-1:0] xor_f;
        logic [2:0]            bar_k;
        logic                  chk_c;
        logic [COLOR_BITS-1:0] grad_r;
        logic [COLOR_BITS-1:0] grad_g;
        logic [COLOR_BITS-1:0] grad_b;
    } s1_t;

    typedef struct packed {
        logic [COLOR_BITS-1:0] r;
        logic [COLOR_BITS-1:0] g;
        logic [COLOR_BITS-1:0] b;
    } rgb_t;

    mode_e                 cur_mode;
    logic                  cur_anim;
    logic [FRAME_BITS-1:0] frame_cnt;
    logic [XW-1:0]         off;
    s1_t                   s1_d, s1_q;
    rgb_t                  rgb_d, rgb_q;
    logic [STAGES:1]       vld_pipe;

    vga_frame_tracker #(
        .XW         (XW),
        .YW         (YW),
        .FRAME_BITS (FRAME_BITS)
    ) u_frame (
        .i_Clk     (i_Clk),
        .rst       (rst),
        .x_pos     (bus.i_x_pos),
        .y_pos     (bus.i_y_pos),
        .valid     (bus.i_valid),
        .req_mode  (bus.i_mode),
        .req_anim  (bus.i_anim_en),
        .mode      (cur_mode),
        .anim      (cur_anim),
        .frame_cnt (frame_cnt)
    );

    // Horizontal scroll offset; the cast zero-extends or truncates to XW.
    assign off = cur_anim ? XW'(frame_cnt) : '0;

    always_comb begin
        s1_d        = '0;
        s1_d.mode   = cur_mode;
        // Sum wraps modulo 2^XW before the XOR with y.
        s1_d.xor_f  = COLOR_BITS'(((bus.i_x_pos + off) ^ XW'(bus.i_y_pos)) >> XOR_SHIFT);
        s1_d.bar_k  = bus.i_x_pos[BAR_SHIFT+2:BAR_SHIFT];
        s1_d.chk_c  = bus.i_x_pos[CHK_SHIFT] ^ bus.i_y_pos[CHK_SHIFT]
                    ^ (cur_anim & frame_cnt[CHK_PHASE_BIT]);
        s1_d.grad_r = bus.i_x_pos[XW-1 -: COLOR_BITS];
        s1_d.grad_g = bus.i_y_pos[YW-1 -: COLOR_BITS];
        s1_d.grad_b = cur_anim ? frame_cnt[FRAME_BITS-1 -: COLOR_BITS] : '0;
    end

    always_comb begin
        rgb_d = '0;
        if (vld_pipe[1]) begin
            case (s1_q.mode)
                MODE_XOR: begin
                    rgb_d.r = s1_q.xor_f;
                    rgb_d.g = s1_q.xor_f;
                    rgb_d.b = s1_q.xor_f;
                end
                MODE_BARS: begin
                    rgb_d.r = {COLOR_BITS{s1_q.bar_k[2]}};
                    rgb_d.g = {COLOR_BITS{s1_q.bar_k[1]}};
                    rgb_d.b = {COLOR_BITS{s1_q.bar_k[0]}};
                end
                MODE_CHECK: begin
                    rgb_d.r = {COLOR_BITS{s1_q.chk_c}};
                    rgb_d.g = {COLOR_BITS{s1_q.chk_c}};
                    rgb_d.b = {COLOR_BITS{s1_q.chk_c}};
                end
                default: begin
                    rgb_d.r = s1_q.grad_r;
                    rgb_d.g = s1_q.grad_g;
                    rgb_d.b = s1_q.grad_b;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            rgb_q    <= '0;
            vld_pipe <= '0;
        end else begin
            s1_q     <= s1_d;
            rgb_q    <= rgb_d;
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
        end
    end

    assign bus.o_r         = rgb_q.r;
    assign bus.o_g         = rgb_q.g;
    assign bus.o_b         = rgb_q.b;
    assign bus.o_valid     = vld_pipe[STAGES];
    assign bus.o_frame_cnt = frame_cnt;

endmodule
